// File: rtl/csr_avmm_bridge_pkg.sv
// Shared types and defaults for the MMIO-to-Avalon-MM CSR bridge.
// The optional read/write timeout is enabled by CSR_AVMM_BRIDGE_TIMEOUT_EN.
package csr_avmm_bridge_pkg;

    localparam int ADDR_W_DEF         = 16;
    localparam int DATA_W_DEF         = 32;
    localparam int TID_W_DEF          = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int TOCNT_W            = 16;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_e;

endpackage

// File: rtl/csr_avmm_bridge_wdog.sv
// Waitrequest watchdog and saturating abort counter for csr_avmm_bridge.
// Only compiled when CSR_AVMM_BRIDGE_TIMEOUT_EN is defined.
`ifdef CSR_AVMM_BRIDGE_TIMEOUT_EN
module csr_avmm_bridge_wdog
    import csr_avmm_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               busy_i,
    input  logic               wait_i,
    output logic               expire_o,
    output logic [TOCNT_W-1:0] count_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOCNT_W-1:0] tocnt_q, tocnt_d;

    // cnt_q holds the number of stalled cycles already seen; once it has
    // reached the limit, a cycle that is still stalled aborts the command.
    assign expire_o = busy_i && wait_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = '0;
        if (busy_i && wait_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        tocnt_d = tocnt_q;
        if (expire_o && (tocnt_q != {TOCNT_W{1'b1}})) begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            tocnt_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign count_o = tocnt_q;

endmodule
`endif

// File: rtl/csr_avmm_bridge.sv
// Single-outstanding MMIO CSR request to Avalon-MM master bridge; writes posted.
// Define CSR_AVMM_BRIDGE_TIMEOUT_EN to abort commands stalled by waitrequest.
module csr_avmm_bridge
    import csr_avmm_bridge_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TID_W          = TID_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk_csr_clk,
    input  logic               csr_reset_n,
    input  logic               mmio_req_valid,
    output logic               mmio_req_ready,
    input  logic               mmio_req_write,
    input  logic [ADDR_W-1:0]  mmio_req_addr,
    input  logic [DATA_W-1:0]  mmio_req_wdata,
    input  logic [TID_W-1:0]   mmio_req_tid,
    output logic               mmio_rsp_valid,
    output logic [DATA_W-1:0]  mmio_rsp_rdata,
    output logic [TID_W-1:0]   mmio_rsp_tid,
    output logic               mmio_rsp_err,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [DATA_W-1:0]  avm_writedata,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_waitrequest,
    output logic [TOCNT_W-1:0] timeout_count
);
    state_e state_q, state_d;
    logic   accept, expire;

    logic              ready_q, ready_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;

    // ready is a register so it stays low through reset and rises one edge later
    assign accept = mmio_req_valid && ready_q;

`ifdef CSR_AVMM_BRIDGE_TIMEOUT_EN
    csr_avmm_bridge_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_csr_clk),
        .rst_ni  (csr_reset_n),
        .busy_i  ((state_q == RD) || (state_q == WR)),
        .wait_i  (avm_waitrequest),
        .expire_o(expire),
        .count_o (timeout_count)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire        = 1'b0;
    assign timeout_count = '0;
`endif

    always_ff @(posedge clk_csr_clk or negedge csr_reset_n) begin
        if (!csr_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = mmio_req_write ? WR : RD;
            WR:      if (!avm_waitrequest || expire) state_d = IDLE;
            RD:      if (!avm_waitrequest || expire) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d     = (state_d == IDLE);
        rd_d        = (state_d == RD);
        wr_d        = (state_d == WR);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tid_d       = tid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_tid_d   = rsp_tid_q;
        rsp_err_d   = rsp_err_q;
        if ((state_q == IDLE) && accept) begin
            addr_d  = mmio_req_addr;
            wdata_d = mmio_req_wdata;
            tid_d   = mmio_req_tid;
        end
        if ((state_q == RD) && (state_d == RSP)) begin
            rsp_valid_d = 1'b1;
            rsp_tid_d   = tid_q;
            rsp_rdata_d = expire ? DATA_W'(TIMEOUT_RDATA) : avm_readdata;
            rsp_err_d   = expire;
        end
    end

    always_ff @(posedge clk_csr_clk or negedge csr_reset_n) begin
        if (!csr_reset_n) begin
            ready_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_tid_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tid_q       <= tid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mmio_req_ready = ready_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign mmio_rsp_valid = rsp_valid_q;
    assign mmio_rsp_rdata = rsp_rdata_q;
    assign mmio_rsp_tid   = rsp_tid_q;
    assign mmio_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_csr_avmm_bridge.sv
// Self-checking bench for csr_avmm_bridge: randomized slave wait states against a transaction-level model.
module tb_csr_avmm_bridge;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int TO = 16;
`ifdef CSR_AVMM_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [TW-1:0] req_tid = '0;
    logic          req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [TW-1:0] rsp_tid;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic [15:0]   timeout_count;

    int n_checks = 0;
    int n_fail   = 0;

    // slave environment
    int            ws_cfg = 0;
    bit            sl_hang = 1'b0;
    bit            sl_busy = 1'b0;
    int            sl_left = 0;
    logic [AW-1:0] sl_addr;
    logic [DW-1:0] sl_data;
    logic          sl_rd;
    int            viol = 0;
    logic [DW-1:0] smem [logic [AW-1:0]];

    // reference model
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            exp_tocnt = 0;

    always #5 clk = ~clk;

    csr_avmm_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .TID_W(TW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_csr_clk    (clk),
        .csr_reset_n    (rst_n),
        .mmio_req_valid (req_valid),
        .mmio_req_ready (req_ready),
        .mmio_req_write (req_write),
        .mmio_req_addr  (req_addr),
        .mmio_req_wdata (req_wdata),
        .mmio_req_tid   (req_tid),
        .mmio_rsp_valid (rsp_valid),
        .mmio_rsp_rdata (rsp_rdata),
        .mmio_rsp_tid   (rsp_tid),
        .mmio_rsp_err   (rsp_err),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .timeout_count  (timeout_count)
    );

    // Avalon slave: ws_cfg wait states per command, or stall forever when sl_hang
    initial begin
        avm_waitrequest = 1'b1;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            if (avm_read && avm_write) viol++;
            if (!rst_n || !(avm_read || avm_write)) begin
                sl_busy         = 1'b0;
                avm_waitrequest = 1'b1;
            end else begin
                if (!sl_busy) begin
                    sl_busy = 1'b1;
                    sl_left = ws_cfg;
                    sl_addr = avm_address;
                    sl_data = avm_writedata;
                    sl_rd   = avm_read;
                end else begin
                    if (avm_address !== sl_addr || avm_read !== sl_rd ||
                        (avm_write && avm_writedata !== sl_data)) viol++;
                    if (sl_left > 0) sl_left--;
                end
                avm_waitrequest = (sl_left != 0) || sl_hang;
                if (!avm_waitrequest) begin
                    if (avm_write) smem[avm_address] = avm_writedata;
                    else avm_readdata = smem.exists(avm_address) ? smem[avm_address]
                                                                 : {16'hA5A5, avm_address};
                end else begin
                    avm_readdata = $urandom;
                end
            end
        end
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {16'hA5A5, a};
    endfunction

    // Issue one request starting at a negedge; checks timing and response against the model.
    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [TW-1:0] t, input int ws, input bit hang, input bit hold);
        int guard, cmd_cnt, wrong_cnt, rsp_cnt, rsp_at, rdy_at, eff, last;
        logic [DW-1:0] exp_rd, got_rd;
        logic [TW-1:0] got_tid;
        logic          got_err, exp_err;
        bit            to_hit;
        to_hit = hang && TO_EN;
        eff    = hang ? TO : ws;
        last   = wr ? eff + 2 : eff + 3;
        exp_rd  = to_hit ? 32'hDEAD_BEEF : ref_read(a);
        exp_err = to_hit;
        cmd_cnt = 0; wrong_cnt = 0; rsp_cnt = 0; rsp_at = 0; rdy_at = 0;
        got_rd = '0; got_tid = '0; got_err = 1'b0;
        ws_cfg = ws; sl_hang = hang;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_tid = t;
        guard = 0;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: ready=%b after %0d cycles, required 1", req_ready, guard);
        end
        @(posedge clk);
        #1;
        if (hold) begin
            req_addr = $urandom; req_wdata = $urandom; req_tid = $urandom; req_write = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (avm_address !== a) begin
                    n_fail++;
                    $display("FAIL avm_address: got %h, required %h", avm_address, a);
                end
                if (wr) begin
                    n_checks++;
                    if (avm_writedata !== d) begin
                        n_fail++;
                        $display("FAIL avm_writedata: got %h, required %h", avm_writedata, d);
                    end
                end
            end
            if (wr ? avm_write : avm_read) cmd_cnt++;
            if (wr ? avm_read : avm_write) wrong_cnt++;
            if (rsp_valid) begin
                rsp_cnt++; rsp_at = k; got_rd = rsp_rdata; got_tid = rsp_tid; got_err = rsp_err;
            end
            if (req_ready && rdy_at == 0) rdy_at = k;
        end
        n_checks++;
        if (cmd_cnt !== eff + 1) begin
            n_fail++;
            $display("FAIL cmd_cycles: got %0d, required %0d", cmd_cnt, eff + 1);
        end
        n_checks++;
        if (wrong_cnt !== 0) begin
            n_fail++;
            $display("FAIL wrong_cmd: got %0d cycles, required 0", wrong_cnt);
        end
        n_checks++;
        if (rdy_at !== last) begin
            n_fail++;
            $display("FAIL ready_return: got cycle N+%0d, required N+%0d", rdy_at, last);
        end
        n_checks++;
        if (rsp_cnt !== (wr ? 0 : 1)) begin
            n_fail++;
            $display("FAIL rsp_count: got %0d, required %0d", rsp_cnt, wr ? 0 : 1);
        end
        if (!wr) begin
            n_checks++;
            if (rsp_at !== eff + 2) begin
                n_fail++;
                $display("FAIL rsp_cycle: got N+%0d, required N+%0d", rsp_at, eff + 2);
            end
            n_checks++;
            if (got_rd !== exp_rd || got_tid !== t || got_err !== exp_err) begin
                n_fail++;
                $display("FAIL rsp_data: got %h/%h/%b, required %h/%h/%b",
                         got_rd, got_tid, got_err, exp_rd, t, exp_err);
            end
            n_checks++;
            if (rsp_rdata !== exp_rd || rsp_tid !== t) begin
                n_fail++;
                $display("FAIL rsp_hold: got %h/%h, required %h/%h", rsp_rdata, rsp_tid, exp_rd, t);
            end
        end
        if (wr && !to_hit) ref_mem[a] = d;
        if (to_hit && exp_tocnt < 16'hFFFF) exp_tocnt++;
        n_checks++;
        if (timeout_count !== 16'(exp_tocnt) || viol !== 0) begin
            n_fail++;
            $display("FAIL tocnt_viol: got %0d/%0d, required %0d/0", timeout_count, viol, exp_tocnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({req_ready, avm_read, avm_write, rsp_valid, rsp_err} !== 5'b0 ||
            avm_address !== '0 || timeout_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/rd/wr/rv/err=%b addr=%h tocnt=%0d, required 0",
                     {req_ready, avm_read, avm_write, rsp_valid, rsp_err}, avm_address, timeout_count);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 16'h0401, 32'h1234_5678, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read();
        smem[16'h2000]    = 32'hCAFE_0001;
        ref_mem[16'h2000] = 32'hCAFE_0001;
        do_txn(1'b0, 16'h2000, 32'h0, 8'h5A, 3, 1'b0, 1'b0);
        // completion in the cycle the stall count reaches the limit still succeeds
        do_txn(1'b0, 16'h0401, 32'h0, 8'h33, TO, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), $urandom,
                   8'($urandom), $urandom_range(0, 5), 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            do_txn(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 3)), $urandom,
                   8'($urandom), $urandom_range(0, 4), 1'b0, (i != 11));
        end
    endtask

`ifdef CSR_AVMM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        do_txn(1'b0, 16'h3000, 32'h0, 8'h11, 0, 1'b1, 1'b0);
        do_txn(1'b1, 16'h3004, 32'h5555_AAAA, 8'h12, 0, 1'b1, 1'b0);
        do_txn(1'b0, 16'h3004, 32'h0, 8'h13, 1, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        int rsp_cnt, rdy_at;
        sl_hang = 1'b1; ws_cfg = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0777; req_tid = 8'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (avm_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_active: got %b, required 1", avm_read);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_tocnt = 0;
        n_checks++;
        if ({avm_read, rsp_valid, req_ready} !== 3'b000 || timeout_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: rd/rv/rdy=%b tocnt=%0d, required 000/0",
                     {avm_read, rsp_valid, req_ready}, timeout_count);
        end
        sl_hang = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        rsp_cnt = 0; rdy_at = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
            if (req_ready && rdy_at == 0) rdy_at = k;
        end
        n_checks++;
        if (rsp_cnt !== 0 || rdy_at !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_release: rsp=%0d ready_at=%0d, required 0/1", rsp_cnt, rdy_at);
        end
        do_txn(1'b0, 16'h0777, 32'h0, 8'h78, 2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
`ifdef CSR_AVMM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "bench time limit");
    end

endmodule
